// File: rtl/mpu_nested.sv
// mpu_nested: memory protection unit for the load/store stage.
// It keeps a LIFO of stack entry points across nested interrupt preemption.
// Each load/store is checked against the live stack frame [sp, ep) and against
// the region map selected by the running task id. A violation is reported
// through a registered fault record that the consumer clears with fault_ack.
module mpu_nested #(
    parameter int AddrWidth = 16,
    parameter int Maps      = 8,
    parameter int Rows      = 4,
    parameter int NestDepth = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [AddrWidth-1:0]           addr,
    input  logic [AddrWidth-1:0]           sp,
    input  logic [6:0]                     op,
    input  logic [$clog2(Maps)-1:0]        id,
    input  logic                           irq_enter,
    input  logic                           irq_exit,
    input  logic                           enable,
    input  logic                           cfg_we,
    input  logic [$clog2(Maps)-1:0]        cfg_map,
    input  logic [$clog2(Rows)-1:0]        cfg_row,
    input  logic [AddrWidth-3:0]           cfg_base,
    input  logic [AddrWidth-1:0]           cfg_len,
    input  logic                           cfg_r,
    input  logic                           cfg_w,
    input  logic                           fault_ack,
    output logic                           fault_valid,
    output logic [AddrWidth-1:0]           fault_addr,
    output logic                           fault_store,
    output logic [$clog2(Maps)-1:0]        fault_id,
    output logic                           fault_lost,
    output logic [$clog2(NestDepth):0]     nest_depth,
    output logic                           nest_err
);

    localparam int IdW  = $clog2(Maps);
    localparam int PtrW = $clog2(NestDepth);
    localparam int DW   = PtrW + 1;
    localparam logic [DW-1:0] Full     = DW'(NestDepth);
    localparam logic [6:0]    OpLoad   = 7'b0000011;
    localparam logic [6:0]    OpStore  = 7'b0100011;

    // Region map storage
    logic [AddrWidth-3:0] base_q [Maps][Rows];
    logic [AddrWidth-1:0] len_q  [Maps][Rows];
    logic                 r_q    [Maps][Rows];
    logic                 w_q    [Maps][Rows];

    // Entry-point stack
    logic [AddrWidth-1:0] stack_q [NestDepth];
    logic [AddrWidth-1:0] ep_q, ep_d;
    logic [DW-1:0]        depth_q, depth_d;
    logic [DW-1:0]        pop_idx;
    logic                 push_en;
    logic                 nest_err_q, nest_err_d;

    // Fault record
    logic                 valid_q, valid_d;
    logic [AddrWidth-1:0] faddr_q, faddr_d;
    logic                 fstore_q, fstore_d;
    logic [IdW-1:0]       fid_q, fid_d;
    logic                 lost_q, lost_d;

    // Access classification
    logic                 is_load, is_store;
    logic                 frame_hit, row_ok, violation;
    logic [AddrWidth-1:0] lo;
    logic [AddrWidth:0]   hi;

    assign is_load   = (op == OpLoad);
    assign is_store  = (op == OpStore);
    assign frame_hit = (addr >= sp) && (addr < ep_q);
    assign violation = enable && (is_load || is_store) && !(frame_hit || row_ok);

    // Region map write port; every row comes out of reset empty and closed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned m = 0; m < Maps; m++) begin
                for (int unsigned r = 0; r < Rows; r++) begin
                    base_q[m][r] <= '0;
                    len_q[m][r]  <= '0;
                    r_q[m][r]    <= 1'b0;
                    w_q[m][r]    <= 1'b0;
                end
            end
        end else if (cfg_we) begin
            base_q[cfg_map][cfg_row] <= cfg_base;
            len_q[cfg_map][cfg_row]  <= cfg_len;
            r_q[cfg_map][cfg_row]    <= cfg_r;
            w_q[cfg_map][cfg_row]    <= cfg_w;
        end
    end

    // OR the permission of every row of map[id] that the address hits
    always_comb begin
        row_ok = 1'b0;
        lo     = '0;
        hi     = '0;
        for (int unsigned r = 0; r < Rows; r++) begin
            lo = {base_q[id][r], 2'b00};
            // one extra bit so a region ending at the top of memory does not wrap
            hi = {1'b0, lo} + {1'b0, len_q[id][r]};
            if ((len_q[id][r] != '0) && (addr >= lo) && ({1'b0, addr} < hi)) begin
                if ((is_load && r_q[id][r]) || (is_store && w_q[id][r])) begin
                    row_ok = 1'b1;
                end
            end
        end
    end

    // Next entry point and stack occupancy from the preemption pulses
    always_comb begin
        ep_d       = ep_q;
        depth_d    = depth_q;
        nest_err_d = nest_err_q;
        push_en    = 1'b0;
        pop_idx    = depth_q - 1'b1;
        if (irq_enter && irq_exit) begin
            ep_d = sp;
        end else if (irq_enter) begin
            ep_d = sp;
            if (depth_q == Full) begin
                nest_err_d = 1'b1;
            end else begin
                push_en = 1'b1;
                depth_d = depth_q + 1'b1;
            end
        end else if (irq_exit) begin
            if (depth_q == '0) begin
                ep_d       = '1;
                nest_err_d = 1'b1;
            end else begin
                ep_d    = stack_q[pop_idx[PtrW-1:0]];
                depth_d = pop_idx;
            end
        end
    end

    // Entry-point register, stack storage and nesting flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ep_q       <= '1;
            depth_q    <= '0;
            nest_err_q <= 1'b0;
            for (int unsigned i = 0; i < NestDepth; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            ep_q       <= ep_d;
            depth_q    <= depth_d;
            nest_err_q <= nest_err_d;
            if (push_en) begin
                stack_q[depth_q[PtrW-1:0]] <= ep_q;
            end
        end
    end

    // Fault record capture, hold, overflow and acknowledge
    always_comb begin
        valid_d  = valid_q;
        faddr_d  = faddr_q;
        fstore_d = fstore_q;
        fid_d    = fid_q;
        lost_d   = lost_q;
        if (violation && (!valid_q || fault_ack)) begin
            valid_d  = 1'b1;
            faddr_d  = addr;
            fstore_d = is_store;
            fid_d    = id;
        end else if (violation) begin
            lost_d = 1'b1;
        end else if (fault_ack) begin
            valid_d = 1'b0;
        end
    end

    // Fault record registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            faddr_q  <= '0;
            fstore_q <= 1'b0;
            fid_q    <= '0;
            lost_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            faddr_q  <= faddr_d;
            fstore_q <= fstore_d;
            fid_q    <= fid_d;
            lost_q   <= lost_d;
        end
    end

    assign fault_valid = valid_q;
    assign fault_addr  = faddr_q;
    assign fault_store = fstore_q;
    assign fault_id    = fid_q;
    assign fault_lost  = lost_q;
    assign nest_depth  = depth_q;
    assign nest_err    = nest_err_q;

endmodule

// File: doc/mpu_nested.md
# mpu_nested

Parametrised memory protection unit for the load/store stage, successor to the single-level per-task stack checker. Tracks a LIFO of stack entry points across nested interrupt preemption, checks each data access against the live stack frame plus a configurable region map per task id, and reports violations through a registered fault record with a valid/ack handshake to the interrupt controller.

## Interface

Parameters:
- AddrWidth, 16, data address width in bits.
- Maps, 8, number of per-task region maps.
- Rows, 4, regions per map.
- NestDepth, 8, entry-point stack depth, power of two.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- addr  in  AddrWidth  effective address of the current access.
- sp  in  AddrWidth  current stack pointer.
- op  in  7  instruction opcode. Only OP_LOAD (0000011) and OP_STORE (0100011) are checked.
- id  in  $clog2(Maps)  running task id; selects the map.
- irq_enter  in  1  one-cycle pulse from the interrupt controller on preemption entry.
- irq_exit  in  1  one-cycle pulse on handler return.
- enable  in  1  when 0, no faults are raised. Tracking and configuration continue.
- cfg_we  in  1  region write strobe.
- cfg_map  in  $clog2(Maps)  target map.
- cfg_row  in  $clog2(Rows)  target row.
- cfg_base  in  AddrWidth-2  region base, word address.
- cfg_len  in  AddrWidth  region length in bytes.
- cfg_r, cfg_w  in  1 each  read and write permission.
- fault_ack  in  1  consumer acknowledge.
- fault_valid  out  1  fault record pending. This is also the n-CLIC fault interrupt line.
- fault_addr  out  AddrWidth  faulting address.
- fault_store  out  1  1 means the fault was a store.
- fault_id  out  $clog2(Maps)  task id at the time of the fault.
- fault_lost  out  1  sticky: a fault was dropped while one was pending.
- nest_depth  out  $clog2(NestDepth)+1  current stack occupancy.
- nest_err  out  1  sticky: push when full or pop when empty.

## Operation

- **Region rows.** Byte base = {cfg_base, 2'b00}.
  - A hit requires base <= addr < base + len.
  - The sum is computed in AddrWidth+1 bits, so there is no wrap.
  - len = 0 never hits.
- **Access permission.** An access is allowed if either of these holds:
  - frame hit: sp <= addr < ep;
  - any hit row in map[id] has cfg_r set (for a load) or cfg_w set (for a store). Permissions OR across rows.
- **Violation.** violation = enable && (op is LOAD or STORE) && !allowed.
- **Entry-point register ep.**
  - Resets to all-ones (the base context owns everything below the top of memory).
  - irq_enter alone: push ep, then ep <= sp.
  - irq_exit alone: ep <= pop.
  - Both in the same cycle (tail-chain): ep <= sp, depth unchanged.
  - Push when depth == NestDepth: the old ep is discarded, ep <= sp, depth is held, nest_err is set.
  - Pop when depth == 0: ep <= all-ones and nest_err is set.
- **Config writes.** cfg_we writes all four fields of map[cfg_map][cfg_row]. On reset, all rows are cleared (len 0, r = w = 0).
- **Fault record.**
  - On a violation with fault_valid = 0: capture addr, store bit and id, and set fault_valid.
  - Record fields are held while fault_valid = 1.
  - fault_ack with fault_valid = 1 clears fault_valid.
  - Violation while fault_valid = 1 and no ack that cycle: the record is kept and fault_lost is set.
  - Violation in the same cycle as ack: the new record is captured and fault_valid stays 1.
- **Sticky flags.** fault_lost and nest_err clear only on reset.

## Timing

- Reset values: fault_valid = 0, fault_addr = 0, fault_store = 0, fault_id = 0, fault_lost = 0, nest_depth = 0, nest_err = 0.
- Reset is asynchronous assert and synchronous-safe deassert. Reset mid-operation discards the stack and any pending fault.
- The permission check is combinational on addr/op/sp/id and uses ep and the map as registered at the start of the cycle.
- fault_valid rises one clock after the violating access cycle.
- An ep change from irq_enter/irq_exit in cycle N is visible to accesses from cycle N+1. An access in cycle N uses the old ep.
- A config write in cycle N affects checks from cycle N+1.
- nest_depth updates one clock after the event.

## Test plan

- **Frame check.** Reset, sp = 0x0F00, irq_enter, then sp = 0x0E00.
  - Load 0x0E80 -> no fault.
  - Load 0x0F00 -> fault_valid next cycle, fault_addr = 0x0F00, fault_store = 0.
- **Region permissions.** Map 2 row 1 = base 0x1000 (cfg_base = 0x400), len 0x100, r = 1, w = 0, with id = 2.
  - Load 0x10FC -> ok.
  - Load 0x1100 -> fault.
  - Store 0x1000 -> fault with fault_store = 1.
  - Set id = 3, load 0x1000 -> fault.
- **Nesting.**
  - Three irq_enter with sp = 0x800, 0x700, 0x600 -> nest_depth = 3, frame = [sp, 0x600).
  - Two irq_exit -> frame upper bound = 0x800.
  - Simultaneous enter+exit with sp = 0x500 -> depth unchanged, ep = 0x500.
- **Nest bounds.**
  - NestDepth + 1 enters -> nest_err = 1, nest_depth = NestDepth.
  - From reset, irq_exit -> nest_err = 1, ep all-ones.
- **Fault handshake.**
  - Two violations in consecutive cycles with no ack -> first record kept, fault_lost = 1.
  - Ack in the same cycle as a third violation -> fault_valid stays 1 and the record updates to the third address.
- **Misc.**
  - enable = 0 -> no faults.
  - Non-memory op with an illegal addr -> no fault.
  - Assert reset mid-nest -> all outputs return to their reset values immediately.
